// File: rtl/hazard_pkg.sv
// Shared encodings for the decode-stage latency scoreboard.
package hazard_pkg;

    // Default latency field width; the top exposes it as a parameter.
    localparam int DEF_LAT_W = 3;

    typedef logic [DEF_LAT_W-1:0] lat_t;

    // Entry encodings: all-zero is free, all-ones waits on a writeback.
    localparam lat_t LAT_FREE = '0;
    localparam lat_t LAT_VAR  = '1;

    // A latency of zero or all-ones on the issue side both mean "variable".
    function automatic logic is_var_lat(input lat_t lat);
        return (lat == LAT_FREE) || (lat == LAT_VAR);
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard counter: set on issue, cleared by writeback when it is
// waiting on a variable-latency result, otherwise counting down to free.
module scoreboard_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [LAT_W-1:0] set_val,
    input  logic             wb_clear,
    output logic [LAT_W-1:0] cnt
);

    localparam logic [LAT_W-1:0] VAR_CODE  = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] FREE_CODE = '0;

    // Priority: new issue, then writeback clear, then countdown, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= FREE_CODE;
        end else if (set) begin
            cnt <= set_val;
        end else if ((cnt == VAR_CODE) && wb_clear) begin
            cnt <= FREE_CODE;
        end else if ((cnt != FREE_CODE) && (cnt != VAR_CODE)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard unit: per-register latency scoreboard gating issue on
// RAW, WAW and drain hazards, with taken-branch flush and a stall counter.
// Handshake: the instruction in decode (issue_valid) leaves exactly in a cycle
// where issue_fire=1; while stall=1 decode must hold the same instruction.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int LAT_W       = DEF_LAT_W,
    parameter int FWD_EN      = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  rs1_decode,
    input  logic [REG_ADDR_W-1:0]  rs2_decode,
    input  logic                   rs1_used,
    input  logic                   rs2_used,
    input  logic [REG_ADDR_W-1:0]  rd_decode,
    input  logic                   rd_write,
    input  logic [LAT_W-1:0]       issue_lat,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   branch_taken,
    input  logic                   drain_req,
    output logic                   stall,
    output logic                   flush_fetch,
    output logic                   flush_decode,
    output logic                   flush_execute,
    output logic                   issue_fire,
    output logic                   drain_done,
    output logic [NUM_REGS-1:0]    pending_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [LAT_W-1:0] VAR_CODE  = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] FREE_CODE = '0;
    // Largest remaining count a consumer may still issue against.
    localparam logic [LAT_W-1:0] FWD_THR   = (FWD_EN != 0) ? LAT_W'(1) : '0;

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic [LAT_W-1:0]               set_val;
    logic [LAT_W-1:0]               c_rs1, c_rs2, c_rd;
    logic                           raw1, raw2, waw, drain_hz, hz;

    // x0 is hardwired free.
    assign cnt[0]          = FREE_CODE;
    assign pending_mask[0] = 1'b0;

    // Zero and all-ones issue latencies both start a writeback-wait entry.
    assign set_val = ((issue_lat == FREE_CODE) || (issue_lat == VAR_CODE)) ? VAR_CODE : issue_lat;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .set      (issue_fire && rd_write && (rd_decode == REG_ADDR_W'(r))),
            .set_val  (set_val),
            .wb_clear (wb_valid && (wb_rd == REG_ADDR_W'(r))),
            .cnt      (cnt[r])
        );
        assign pending_mask[r] = (cnt[r] != FREE_CODE);
    end

    // Hazard detection, branch priority and issue handshake.
    always_comb begin
        c_rs1 = cnt[rs1_decode];
        c_rs2 = cnt[rs2_decode];
        c_rd  = cnt[rd_decode];

        raw1 = rs1_used && (rs1_decode != '0) && ((c_rs1 == VAR_CODE) || (c_rs1 > FWD_THR));
        raw2 = rs2_used && (rs2_decode != '0) && ((c_rs2 == VAR_CODE) || (c_rs2 > FWD_THR));
        waw  = rd_write && (rd_decode != '0) && (c_rd != FREE_CODE) &&
               ((c_rd == VAR_CODE) || (issue_lat == FREE_CODE) || (c_rd >= issue_lat));
        drain_hz = drain_req && (pending_mask != '0);
        hz       = issue_valid && (raw1 || raw2 || waw || drain_hz);

        flush_fetch   = branch_taken;
        flush_decode  = branch_taken;
        flush_execute = branch_taken;
        stall         = hz && !branch_taken;
        issue_fire    = issue_valid && !stall && !branch_taken;
        drain_done    = (pending_mask == '0);
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: a forwarding instance with a
// 16-bit stall counter and a non-forwarding instance with a 3-bit counter.
module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  rs1_decode = '0, rs2_decode = '0, rd_decode = '0, wb_rd = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0, rd_write = 1'b0;
    logic [2:0]  issue_lat = '0;
    logic        wb_valid = 1'b0, branch_taken = 1'b0, drain_req = 1'b0;

    logic        stall, flush_fetch, flush_decode, flush_execute, issue_fire, drain_done;
    logic [31:0] pending_mask;
    logic [15:0] stall_cycles;

    logic        nf_stall, nf_ff, nf_fd, nf_fe, nf_fire, nf_drain_done;
    logic [31:0] nf_pending_mask;
    logic [2:0]  nf_stall_cycles;

    int vectors = 0;
    int errors  = 0;
    int exp_sc  = 0;

    hazard_scoreboard_unit #(.FWD_EN(1), .STALL_CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_decode(rd_decode), .rd_write(rd_write), .issue_lat(issue_lat),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_taken(branch_taken), .drain_req(drain_req),
        .stall(stall), .flush_fetch(flush_fetch), .flush_decode(flush_decode),
        .flush_execute(flush_execute), .issue_fire(issue_fire), .drain_done(drain_done),
        .pending_mask(pending_mask), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard_unit #(.FWD_EN(0), .STALL_CNT_W(3)) u_dut_nf (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_decode(rd_decode), .rd_write(rd_write), .issue_lat(issue_lat),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_taken(branch_taken), .drain_req(drain_req),
        .stall(nf_stall), .flush_fetch(nf_ff), .flush_decode(nf_fd),
        .flush_execute(nf_fe), .issue_fire(nf_fire), .drain_done(nf_drain_done),
        .pending_mask(nf_pending_mask), .stall_cycles(nf_stall_cycles)
    );

    // Clock.
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, checks run 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 1'b0; rs1_decode = '0; rs2_decode = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd_decode = '0; rd_write = 1'b0; issue_lat = '0;
        wb_valid = 1'b0; wb_rd = '0; branch_taken = 1'b0; drain_req = 1'b0;
    endtask

    task automatic issue(input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
                         input logic [4:0] d, input logic w, input logic [2:0] lat);
        issue_valid = 1'b1; rs1_decode = s1; rs1_used = u1; rs2_decode = s2; rs2_used = u2;
        rd_decode = d; rd_write = w; issue_lat = lat;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        exp_sc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall); end
        vectors++; if ({flush_fetch, flush_decode, flush_execute} !== 3'b000) begin errors++; $display("FAIL rst_flush got %b exp 000", {flush_fetch, flush_decode, flush_execute}); end
        vectors++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL rst_fire got %0b exp 0", issue_fire); end
        vectors++; if (drain_done !== 1'b1) begin errors++; $display("FAIL rst_drain_done got %0b exp 1", drain_done); end
        vectors++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL rst_pending got %h exp 0", pending_mask); end
        vectors++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL rst_stall_cycles got %0d exp 0", stall_cycles); end
        next_cycle();
    endtask

    // Load x5, then add x6,x5,x1 stalls on the pending load; left stalled.
    task automatic test_load_use();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0);
        #1;
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL lu_load_fire got %0b exp 1", issue_fire); end
        next_cycle();
        issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 3'd1);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall[%0d] got %0b exp 1", i, stall); end
            vectors++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL lu_fire[%0d] got %0b exp 0", i, issue_fire); end
            vectors++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL lu_pending[%0d] got %h exp 20", i, pending_mask); end
            exp_sc++;
            next_cycle();
        end
    endtask

    // Taken branch overrides the stall, then the load writeback releases the add.
    task automatic test_branch_flush();
        branch_taken = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL br_stall got %0b exp 0", stall); end
        vectors++; if ({flush_fetch, flush_decode, flush_execute} !== 3'b111) begin errors++; $display("FAIL br_flush got %b exp 111", {flush_fetch, flush_decode, flush_execute}); end
        vectors++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL br_fire got %0b exp 0", issue_fire); end
        next_cycle();
        branch_taken = 1'b0;
        #1;
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL br_after_stall got %0b exp 1", stall); end
        vectors++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL br_after_pending got %h exp 20", pending_mask); end
        exp_sc++;
        next_cycle();
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL wb_cycle_stall got %0b exp 1", stall); end
        exp_sc++;
        next_cycle();
        wb_valid = 1'b0; wb_rd = '0;
        #1;
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL lu_release_fire got %0b exp 1", issue_fire); end
        vectors++; if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL lu_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
        next_cycle();
        idle();
        #1;
        vectors++; if (pending_mask !== 32'h40) begin errors++; $display("FAIL lu_x6_pending got %h exp 40", pending_mask); end
        next_cycle();
        #1;
        vectors++; if (drain_done !== 1'b1) begin errors++; $display("FAIL lu_idle_drain got %0b exp 1", drain_done); end
    endtask

    // mul x7 lat 3 then a reader: 2 stalls with forwarding, 3 without.
    task automatic test_fwd_latency();
        do_reset();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd3);
        #1;
        vectors++; if ({issue_fire, nf_fire} !== 2'b11) begin errors++; $display("FAIL fwd_mul_fire got %b exp 11", {issue_fire, nf_fire}); end
        next_cycle();
        issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (stall !== (i < 2)) begin errors++; $display("FAIL fwd_stall[%0d] got %0b exp %0b", i, stall, (i < 2)); end
            vectors++; if (nf_stall !== (i < 3)) begin errors++; $display("FAIL nofwd_stall[%0d] got %0b exp %0b", i, nf_stall, (i < 3)); end
            if (i < 2) exp_sc++;
            next_cycle();
        end
        idle();
        #1;
        vectors++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL fwd_stall_cycles got %0d exp 2", stall_cycles); end
        vectors++; if (nf_stall_cycles !== 3'd3) begin errors++; $display("FAIL nofwd_stall_cycles got %0d exp 3", nf_stall_cycles); end
        next_cycle();
    endtask

    // lat-4 write to x9 then lat-1 write to x9 waits until x9 is free.
    task automatic test_waw();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd4);
        #1;
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL waw_first_fire got %0b exp 1", issue_fire); end
        next_cycle();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (stall !== (i < 4)) begin errors++; $display("FAIL waw_stall[%0d] got %0b exp %0b", i, stall, (i < 4)); end
            if (i < 4) exp_sc++;
            next_cycle();
        end
        idle();
        #1;
        vectors++; if (pending_mask !== 32'h200) begin errors++; $display("FAIL waw_pending got %h exp 200", pending_mask); end
        vectors++; if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL waw_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
        next_cycle();
    endtask

    // Same-cycle writeback and load issue, plus writeback corner cases.
    task automatic test_wb_same_cycle();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL wbs_fire got %0b exp 1", issue_fire); end
        next_cycle();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd0;
        #1;
        vectors++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL wbs_pending got %h exp 20", pending_mask); end
        next_cycle();
        // Lat 7 on input behaves as variable; same cycle retires x5.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd7);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        vectors++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL wb_x0_ignored got %h exp 20", pending_mask); end
        next_cycle();
        idle();
        #1;
        vectors++; if (pending_mask !== 32'h400) begin errors++; $display("FAIL latvar_pending got %h exp 400", pending_mask); end
        next_cycle();
        #1;
        vectors++; if (pending_mask !== 32'h400) begin errors++; $display("FAIL latvar_hold got %h exp 400", pending_mask); end
        wb_valid = 1'b1; wb_rd = 5'd10;
        next_cycle();
        // Fixed-latency x13 ignores a stray writeback; x0 write is not tracked.
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 3'd2);
        wb_valid = 1'b0; wb_rd = '0;
        #1;
        vectors++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL latvar_clear got %h exp 0", pending_mask); end
        next_cycle();
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd3);
        wb_valid = 1'b1; wb_rd = 5'd13;
        #1;
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL x0_fire got %0b exp 1", issue_fire); end
        next_cycle();
        idle();
        #1;
        vectors++; if (pending_mask !== 32'h2000) begin errors++; $display("FAIL fixed_wb_ignored got %h exp 2000", pending_mask); end
        next_cycle();
        #1;
        vectors++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL fixed_drained got %h exp 0", pending_mask); end
    endtask

    // Fence with two pending entries holds issue until both retire.
    task automatic test_drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0);
        next_cycle();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 3'd3);
        next_cycle();
        idle();
        drain_req = 1'b1;
        #1;
        vectors++; if ({stall, drain_done} !== 2'b00) begin errors++; $display("FAIL drain_novalid got %b exp 00", {stall, drain_done}); end
        next_cycle();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin wb_valid = 1'b1; wb_rd = 5'd5; end
            #1;
            vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL drain_stall[%0d] got %0b exp 1", i, stall); end
            vectors++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_done[%0d] got %0b exp 0", i, drain_done); end
            exp_sc++;
            next_cycle();
        end
        wb_valid = 1'b0; wb_rd = '0;
        #1;
        vectors++; if ({stall, issue_fire, drain_done} !== 3'b011) begin errors++; $display("FAIL drain_release got %b exp 011", {stall, issue_fire, drain_done}); end
        vectors++; if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL drain_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
        next_cycle();
        idle();
    endtask

    // Long load-use stall: the 3-bit counter pins at 7.
    task automatic test_saturate();
        do_reset();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0);
        next_cycle();
        issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 3'd1);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
        end
        #1;
        vectors++; if (stall_cycles !== 16'd10) begin errors++; $display("FAIL sat_wide got %0d exp 10", stall_cycles); end
        vectors++; if (nf_stall_cycles !== 3'd7) begin errors++; $display("FAIL sat_narrow got %0d exp 7", nf_stall_cycles); end
        wb_valid = 1'b1; wb_rd = 5'd5;
        next_cycle();
        wb_valid = 1'b0; wb_rd = '0;
        #1;
        vectors++; if (nf_fire !== 1'b1) begin errors++; $display("FAIL sat_release got %0b exp 1", nf_fire); end
        next_cycle();
        idle();
    endtask

    // Reset with live entries and an in-flight writeback wipes everything.
    task automatic test_reset_mid();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0);
        next_cycle();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 3'd5);
        next_cycle();
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        #1;
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_prestall got %0b exp 1", stall); end
        next_cycle();
        rst = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd5;
        next_cycle();
        #1;
        vectors++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL mid_pending got %h exp 0", pending_mask); end
        rst = 1'b0;
        idle();
        #1;
        vectors++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL mid_stall_cycles got %0d exp 0", stall_cycles); end
        vectors++; if ({stall, drain_done} !== 2'b01) begin errors++; $display("FAIL mid_outputs got %b exp 01", {stall, drain_done}); end
        next_cycle();
    endtask

    initial begin
        idle();
        next_cycle();
        test_reset();
        test_load_use();
        test_branch_flush();
        test_fwd_latency();
        test_waw();
        test_wb_same_cycle();
        test_drain();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
